// File: rtl/step_scheduler_if.sv
// Requester/counter-side signal bundle for step_scheduler.
// master = requesters plus counter observer, slave = the scheduler.
interface step_scheduler_if #(
   parameter int unsigned POS_W = 2
) ();
   logic             req_a;
   logic [POS_W-1:0] tgt_a;
   logic             ack_a;
   logic             req_b;
   logic [POS_W-1:0] tgt_b;
   logic             ack_b;
   logic             step_out;
   logic [POS_W-1:0] pos;
   logic             busy;

   modport master (
      output req_a, tgt_a, req_b, tgt_b,
      input  ack_a, ack_b, step_out, pos, busy
   );

   modport slave (
      input  req_a, tgt_a, req_b, tgt_b,
      output ack_a, ack_b, step_out, pos, busy
   );
endinterface

// File: rtl/step_scheduler.sv
// Round-robin arbiter that walks a shared modulo counter forward to each requester's target.
// Optional FB_CHECK_EN adds fb_pos/fb_err to compare the counter's real state against pos.
module step_scheduler #(
   parameter int unsigned POS_W = 2,
   parameter int unsigned GAP   = 3
) (
   input  logic             clk,
   input  logic             rst,
`ifdef FB_CHECK_EN
   input  logic [POS_W-1:0] fb_pos,
   output logic             fb_err,
`endif
   step_scheduler_if.slave  bus
);

   localparam int unsigned   GW      = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GapLoad = (GAP > 0) ? GW'(GAP - 1) : '0;

   typedef enum logic [1:0] {StIdle, StStep, StWait, StDone} state_e;

   state_e           state_q, state_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [POS_W-1:0] tgt_q, tgt_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic             owner_q, owner_d;   // 0 = A, 1 = B
   logic             last_q, last_d;
   logic             step_q, ack_a_q, ack_b_q, busy_q;
   logic             blocked;
   logic             grant_a, grant_b;

`ifdef FB_CHECK_EN
   logic fb_err_q, fb_err_d;

   assign blocked = fb_err_q;
   assign fb_err  = fb_err_q;

   always_comb begin
      fb_err_d = fb_err_q;
      if ((state_q == StIdle || state_q == StDone) && fb_pos != pos_q) begin
         fb_err_d = 1'b1;
      end
   end
`else
   assign blocked = 1'b0;
`endif

   // On a tie the requester not served last wins.
   assign grant_b = bus.req_b & (~bus.req_a | ~last_q);
   assign grant_a = bus.req_a & ~grant_b;

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      tgt_d   = tgt_q;
      gap_d   = gap_q;
      owner_d = owner_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (!blocked && (grant_a || grant_b)) begin
               owner_d = grant_b;
               tgt_d   = grant_b ? bus.tgt_b : bus.tgt_a;
               state_d = (tgt_d == pos_q) ? StDone : StStep;
            end
         end
         StStep: begin
            pos_d = pos_q + 1'b1;
            if (pos_d == tgt_q) begin
               state_d = StDone;
            end else if (GAP > 0) begin
               state_d = StWait;
               gap_d   = GapLoad;
            end else begin
               state_d = StStep;
            end
         end
         StWait: begin
            if (gap_q == '0) begin
               state_d = StStep;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         StDone: begin
            last_d  = owner_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         pos_q   <= '0;
         tgt_q   <= '0;
         gap_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         step_q  <= 1'b0;
         ack_a_q <= 1'b0;
         ack_b_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         tgt_q   <= tgt_d;
         gap_q   <= gap_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         // Outputs are decoded from the next state so they line up with it.
         step_q  <= (state_d == StStep);
         ack_a_q <= (state_d == StDone) && !owner_d;
         ack_b_q <= (state_d == StDone) && owner_d;
         busy_q  <= (state_d != StIdle);
      end
   end

`ifdef FB_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fb_err_q <= 1'b0;
      end else begin
         fb_err_q <= fb_err_d;
      end
   end
`endif

   assign bus.step_out = step_q;
   assign bus.ack_a    = ack_a_q;
   assign bus.ack_b    = ack_b_q;
   assign bus.busy     = busy_q;
   assign bus.pos      = pos_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Self-checking bench for step_scheduler: directed table, hand sequences and random traffic
// checked against a round-robin / modular-distance reference model.
module tb_step_scheduler;
   localparam int unsigned POS_W = 2;
   localparam int unsigned GAP   = 3;
   localparam int          MOD   = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   step_scheduler_if #(.POS_W(POS_W)) bus ();

`ifdef FB_CHECK_EN
   logic [POS_W-1:0] fb_pos;
   logic [POS_W-1:0] cnt;
   logic             fb_err;
   logic             fb_force;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (bus.step_out) cnt <= cnt + 1'b1;
   end
   assign fb_pos = fb_force ? 2'd2 : cnt;
`endif

   step_scheduler #(.POS_W(POS_W), .GAP(GAP)) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef FB_CHECK_EN
      .fb_pos(fb_pos),
      .fb_err(fb_err),
`endif
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int pos_m;
   int last_m;

   typedef struct {
      bit         fresh;
      bit         ra;
      bit         rb;
      logic [1:0] ta;
      logic [1:0] tb;
      int         owner;
      int         steps;
      int         pos;
   } vec_t;
   vec_t tbl[7];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lat(input int steps);
      return (steps == 0) ? 1 : 1 + steps + (steps - 1) * int'(GAP);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      bus.tgt_a = '0;
      bus.tgt_b = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic idle_prelude();
      @(posedge clk);
      #1;
      check("idle_busy", bus.busy, 0);
      check("idle_step", bus.step_out, 0);
   endtask

   // Runs one grant to completion; extra=1 when an IDLE cycle precedes the grant.
   task automatic serve(input int extra, input int owner, input int steps, input int exp_pos);
      int k = 0;
      int pulses = 0;
      bit got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(posedge clk);
         #1;
         k++;
         if (bus.step_out) begin
            check("step_slot", k, extra + 1 + pulses * (int'(GAP) + 1));
            pulses++;
         end
         if (k == extra + 1) begin
            if (owner == 0) bus.tgt_a = 2'($urandom_range(3, 0));
            else            bus.tgt_b = 2'($urandom_range(3, 0));
         end
         if (bus.ack_a || bus.ack_b) got = 1'b1;
      end
      check("ack_seen", int'(got), 1);
      if (got) begin
         check("ack_a", bus.ack_a, int'(owner == 0));
         check("ack_b", bus.ack_b, int'(owner == 1));
         check("ack_cycle", k, extra + lat(steps));
         check("step_count", pulses, steps);
         check("pos", bus.pos, exp_pos);
         check("busy_done", bus.busy, 1);
      end
      if (owner == 0) bus.req_a = 1'b0;
      else            bus.req_b = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int mode, first, second, t, steps;
      logic [1:0] ta, tb;
`ifdef FB_CHECK_EN
      fb_force = 1'b0;
`endif
      tbl[0] = '{1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 0, 3, 3};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 1, 2, 1};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 0, 0, 1};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 2'd2, 2'd0, 1, 3, 0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 0, 2, 2};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 2'd2, 2'd3, 1, 1, 3};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 0, 3, 2};

      // Reset values, during and right after reset
      rst = 1'b1;
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      bus.tgt_a = '0;
      bus.tgt_b = '0;
      #2;
      check("rst_pos", bus.pos, 0);
      check("rst_busy", bus.busy, 0);
      do_reset();
      @(posedge clk);
      #1;
      check("post_rst_pos", bus.pos, 0);
      check("post_rst_step", bus.step_out, 0);
      check("post_rst_ack_a", bus.ack_a, 0);
      check("post_rst_ack_b", bus.ack_b, 0);
      check("post_rst_busy", bus.busy, 0);

      // Simultaneous requests straight after reset: A first, then B
      bus.req_a = 1'b1;
      bus.tgt_a = 2'd1;
      bus.req_b = 1'b1;
      bus.tgt_b = 2'd2;
      serve(0, 0, 1, 1);
      serve(1, 1, 1, 2);

      // Directed table from a fresh reset
      do_reset();
      foreach (tbl[i]) begin
         if (tbl[i].fresh) begin
            idle_prelude();
            bus.req_a = tbl[i].ra;
            bus.req_b = tbl[i].rb;
            bus.tgt_a = tbl[i].ta;
            bus.tgt_b = tbl[i].tb;
         end
         serve(tbl[i].fresh ? 0 : 1, tbl[i].owner, tbl[i].steps, tbl[i].pos);
      end
      pos_m  = 2;
      last_m = 0;

      // Random traffic against the reference model
      for (int it = 0; it < 40; it++) begin
         idle_prelude();
         mode = int'($urandom_range(3, 1));
         ta = 2'($urandom_range(3, 0));
         tb = 2'($urandom_range(3, 0));
         bus.tgt_a = ta;
         bus.tgt_b = tb;
         bus.req_a = (mode != 2);
         bus.req_b = (mode != 1);
         if (mode == 3) first = (last_m == 1) ? 0 : 1;
         else           first = (mode == 1) ? 0 : 1;
         t = (first == 0) ? int'(ta) : int'(tb);
         steps = (t - pos_m + MOD) % MOD;
         pos_m = (pos_m + steps) % MOD;
         serve(0, first, steps, pos_m);
         last_m = first;
         if (mode == 3) begin
            second = 1 - first;
            t = (second == 0) ? int'(ta) : int'(tb);
            steps = (t - pos_m + MOD) % MOD;
            pos_m = (pos_m + steps) % MOD;
            serve(1, second, steps, pos_m);
            last_m = second;
         end
      end

      // Reset in the middle of a gap between steps
      do_reset();
      idle_prelude();
      bus.req_a = 1'b1;
      bus.tgt_a = 2'd3;
      repeat (2) @(posedge clk);
      #1;
      check("pre_abort_busy", bus.busy, 1);
      rst = 1'b1;
      #1;
      check("abort_step", bus.step_out, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_pos", bus.pos, 0);
      check("abort_ack_a", bus.ack_a, 0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("abort_hold_ack", bus.ack_a, 0);
      end
      bus.req_a = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("after_abort_busy", bus.busy, 0);
      check("after_abort_pos", bus.pos, 0);

`ifdef FB_CHECK_EN
      check("fb_err_clear", fb_err, 0);
      fb_force = 1'b1;
      @(posedge clk);
      #1;
      check("fb_err_set", fb_err, 1);
      fb_force = 1'b0;
      bus.req_a = 1'b1;
      bus.tgt_a = 2'd1;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("fb_blocked_busy", bus.busy, 0);
         check("fb_sticky", fb_err, 1);
      end
      bus.req_a = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
